// File: rtl/oh_gpio_ctrl_regs.sv
// oh_gpio_ctrl_regs: register map, pad config layout and shared types for
// the GPIO controller. Imported by oh_gpio_ctrl and its sub-modules.
package oh_gpio_ctrl_regs;

  // Word addresses on the register port
  localparam logic [5:0] GPIO_OUT      = 6'h00;
  localparam logic [5:0] GPIO_OEN      = 6'h01;
  localparam logic [5:0] GPIO_IE       = 6'h02;
  localparam logic [5:0] GPIO_IN       = 6'h03;
  localparam logic [5:0] GPIO_IMASK    = 6'h04;
  localparam logic [5:0] GPIO_IRISE    = 6'h05;
  localparam logic [5:0] GPIO_IFALL    = 6'h06;
  localparam logic [5:0] GPIO_ISTAT    = 6'h07;
  localparam logic [5:0] GPIO_CFG_BASE = 6'h20;

  // Per-pin IOBUF config field layout
  localparam int unsigned CFG_W      = 8;
  localparam int unsigned CFG_PE     = 0;
  localparam int unsigned CFG_PS     = 1;
  localparam int unsigned CFG_SL     = 2;
  localparam int unsigned CFG_ST     = 3;
  localparam int unsigned CFG_DS_LSB = 4;
  localparam int unsigned CFG_DS_MSB = 7;

  // Packed view of one pin's config byte (pe is bit 0)
  typedef struct packed {
    logic [3:0] ds;
    logic       st;
    logic       sl;
    logic       ps;
    logic       pe;
  } pad_cfg_t;

  // Edge-detect warm-up state after reset
  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } warm_state_e;

  // Any address at or above the CFG window base targets a per-pin CFG slot
  function automatic logic is_cfg_addr(input logic [5:0] addr);
    return (addr >= GPIO_CFG_BASE);
  endfunction

endpackage

// File: rtl/oh_dsync.sv
// oh_dsync: vector-wide multi-flop synchronizer, one SYNC-deep chain per bit.
// Ports:
//   clk    - destination clock
//   nreset - synchronous active-low reset, clears every stage to 0
//   din_i  - asynchronous input vector
//   dout_o - synchronized output (last stage of each chain)
module oh_dsync #(
  parameter int unsigned DW   = 1,
  parameter int unsigned SYNC = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o
);

  logic [SYNC-1:0][DW-1:0] sync_q;

  // Shift chain: stage 0 samples the pad, stage SYNC-1 is the output
  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], din_i};
    end
  end

  assign dout_o = sync_q[SYNC-1];

endmodule

// File: rtl/oh_gpio_ctrl.sv
// oh_gpio_ctrl: register-mapped GPIO controller feeding oh_pads_gpio.
// Drives dout/oen/ie/cfg straight from registers, resynchronizes din,
// detects rise/fall edges into W1C status bits and raises a level irq.
// Ports:
//   clk, nreset           - core clock, synchronous active-low reset
//   reg_access/reg_write  - single-cycle register request (write when 1)
//   reg_addr/reg_wdata    - word address and write data
//   reg_rdata/reg_rvalid  - read data and one-cycle response strobe
//   dout/oen/ie/cfg       - pad controls (cfg pin i at cfg[8*i+:8])
//   din                   - asynchronous pad input data
//   irq                   - registered level interrupt
module oh_gpio_ctrl
  import oh_gpio_ctrl_regs::*;
#(
  parameter int unsigned NGPIO     = 8,
  parameter int unsigned SYNC      = 2,
  parameter logic [7:0]  CFG_RESET = 8'h00
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   reg_access,
  input  logic                   reg_write,
  input  logic [5:0]             reg_addr,
  input  logic [31:0]            reg_wdata,
  output logic [31:0]            reg_rdata,
  output logic                   reg_rvalid,
  output logic [NGPIO-1:0]       dout,
  output logic [NGPIO-1:0]       oen,
  output logic [NGPIO-1:0]       ie,
  output logic [NGPIO*CFG_W-1:0] cfg,
  input  logic [NGPIO-1:0]       din,
  output logic                   irq
);

  localparam int unsigned CNT_W = $clog2(SYNC + 1);

  // Architectural registers
  logic [NGPIO-1:0] out_q,   out_d;
  logic [NGPIO-1:0] oen_q,   oen_d;
  logic [NGPIO-1:0] ie_q,    ie_d;
  logic [NGPIO-1:0] imask_q, imask_d;
  logic [NGPIO-1:0] irise_q, irise_d;
  logic [NGPIO-1:0] ifall_q, ifall_d;
  logic [NGPIO-1:0] istat_q, istat_d;
  pad_cfg_t [NGPIO-1:0] cfg_q, cfg_d;

  // Input path and response registers
  logic [NGPIO-1:0] p_q;
  logic [31:0]      rdata_q;
  logic             rvalid_q;
  logic             irq_q,  irq_d;
  warm_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;

  // Combinational helpers
  logic             wr_c;
  logic             rd_c;
  logic [NGPIO-1:0] wdata_c;
  logic [NGPIO-1:0] sync_c;
  logic [NGPIO-1:0] rise_c;
  logic [NGPIO-1:0] fall_c;
  logic [NGPIO-1:0] ev_c;
  logic [NGPIO-1:0] istat_clr_c;
  logic [31:0]      rdata_c;
  logic             unused_wdata;

  assign wr_c         = reg_access & reg_write;
  assign rd_c         = reg_access & ~reg_write;
  assign wdata_c      = reg_wdata[NGPIO-1:0];
  assign unused_wdata = ^reg_wdata;

  // Pad input resynchronizer
  oh_dsync #(
    .DW   (NGPIO),
    .SYNC (SYNC)
  ) u_dsync (
    .clk    (clk),
    .nreset (nreset),
    .din_i  (din),
    .dout_o (sync_c)
  );

  // Edge detection; suppressed while the synchronizer pipeline fills
  assign rise_c = sync_c & ~p_q;
  assign fall_c = ~sync_c & p_q;
  assign ev_c   = (state_q == RUN) ? ((rise_c & irise_q) | (fall_c & ifall_q))
                                   : '0;

  // Register write decode and status/irq next state
  always_comb begin
    out_d       = out_q;
    oen_d       = oen_q;
    ie_d        = ie_q;
    imask_d     = imask_q;
    irise_d     = irise_q;
    ifall_d     = ifall_q;
    cfg_d       = cfg_q;
    istat_clr_c = '0;
    if (wr_c) begin
      case (reg_addr)
        GPIO_OUT:   out_d       = wdata_c;
        GPIO_OEN:   oen_d       = wdata_c;
        GPIO_IE:    ie_d        = wdata_c;
        GPIO_IMASK: imask_d     = wdata_c;
        GPIO_IRISE: irise_d     = wdata_c;
        GPIO_IFALL: ifall_d     = wdata_c;
        GPIO_ISTAT: istat_clr_c = wdata_c;
        default: ;
      endcase
      if (is_cfg_addr(reg_addr)) begin
        for (int unsigned i = 0; i < NGPIO; i++) begin
          if (reg_addr[4:0] == 5'(i)) begin
            cfg_d[i] = pad_cfg_t'(reg_wdata[CFG_W-1:0]);
          end
        end
      end
    end
    // A new event on a bit overrides a same-cycle W1C of that bit
    istat_d = (istat_q & ~istat_clr_c) | ev_c;
    irq_d   = |(istat_q & imask_q);
  end

  // Read data mux; unmapped and out-of-range CFG slots read as 0
  always_comb begin
    rdata_c = '0;
    case (reg_addr)
      GPIO_OUT:   rdata_c = 32'(out_q);
      GPIO_OEN:   rdata_c = 32'(oen_q);
      GPIO_IE:    rdata_c = 32'(ie_q);
      GPIO_IN:    rdata_c = 32'(sync_c);
      GPIO_IMASK: rdata_c = 32'(imask_q);
      GPIO_IRISE: rdata_c = 32'(irise_q);
      GPIO_IFALL: rdata_c = 32'(ifall_q);
      GPIO_ISTAT: rdata_c = 32'(istat_q);
      default: begin
        if (is_cfg_addr(reg_addr)) begin
          for (int unsigned i = 0; i < NGPIO; i++) begin
            if (reg_addr[4:0] == 5'(i)) begin
              rdata_c = 32'(cfg_q[i]);
            end
          end
        end
      end
    endcase
  end

  // State registers, warm-up FSM and read response
  always_ff @(posedge clk) begin
    if (!nreset) begin
      out_q    <= '0;
      oen_q    <= '1;
      ie_q     <= '0;
      imask_q  <= '0;
      irise_q  <= '0;
      ifall_q  <= '0;
      istat_q  <= '0;
      cfg_q    <= {NGPIO{CFG_RESET}};
      p_q      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      state_q  <= WARM;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      oen_q    <= oen_d;
      ie_q     <= ie_d;
      imask_q  <= imask_d;
      irise_q  <= irise_d;
      ifall_q  <= ifall_d;
      istat_q  <= istat_d;
      cfg_q    <= cfg_d;
      p_q      <= sync_c;
      irq_q    <= irq_d;
      rvalid_q <= rd_c;
      if (rd_c) begin
        rdata_q <= rdata_c;
      end
      // WARM spans counts 0..SYNC, i.e. SYNC+1 cycles with edges masked
      case (state_q)
        WARM: begin
          if (cnt_q == CNT_W'(SYNC)) begin
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RUN:     state_q <= RUN;
        default: state_q <= WARM;
      endcase
    end
  end

  assign dout       = out_q;
  assign oen        = oen_q;
  assign ie         = ie_q;
  assign cfg        = cfg_q;
  assign irq        = irq_q;
  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;

endmodule
